pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-look-ahead adder/subtractor. It is the next generation of the team's combinational `cla` block.
- The SIZE-bit operation is split into BLOCK-bit CLA slices, one slice per pipeline stage.
- The carry between slices is registered.
- Valid/ready handshakes on input and output allow insertion into streaming datapaths with backpressure.

---
 rtl/pipelined_cla_adder.sv | 178 +++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: an adder/subtractor built from carry-look-ahead slices,
// with one BLOCK-bit slice evaluated per pipeline stage and a valid/ready
// handshake on both sides.
// Optional feature: define PIPELINED_CLA_SAT_EN to saturate S on signed
// overflow. Without the macro, S is the plain modular result and no saturation
// logic is built.
module pipelined_cla_adder #(
   parameter  int SIZE   = 32,
   parameter  int BLOCK  = 8,
   localparam int STAGES = (BLOCK > 0) ? SIZE / BLOCK : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] A,
   input  logic [SIZE-1:0] B,
   input  logic            Cin,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] S,
   output logic            Cout,
   output logic            Ovf
);

   localparam int LAST = STAGES - 1;

   generate
      if ((BLOCK < 1) || ((SIZE % ((BLOCK < 1) ? 1 : BLOCK)) != 0)) begin : g_param_check
         $error("pipelined_cla_adder: SIZE must be a positive multiple of BLOCK");
      end
   endgenerate

   typedef struct packed {
      logic             cout;
      logic             cmsb;
      logic [BLOCK-1:0] sum;
   } slice_t;

   // Each carry is a flat sum of products of g/p terms, so no carry inside the
   // slice depends on a neighbouring carry. cmsb is the carry into the slice's
   // top bit, which gives the overflow term when this is the top slice.
   function automatic slice_t cla_slice(input logic [BLOCK-1:0] a,
                                        input logic [BLOCK-1:0] b,
                                        input logic             ci);
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   c;
      logic             term;
      logic             prod;
      slice_t           res;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         term = 1'b0;
         prod = 1'b1;
         for (int j = i; j >= 0; j--) begin
            term = term | (g[j] & prod);
            prod = prod & p[j];
         end
         c[i+1] = term | (prod & ci);
      end
      res.sum  = p ^ c[BLOCK-1:0];
      res.cmsb = c[BLOCK-1];
      res.cout = c[BLOCK];
      return res;
   endfunction

`ifdef PIPELINED_CLA_SAT_EN
   // The wrapped MSB is opposite to the true sign whenever overflow occurred.
   function automatic logic [SIZE-1:0] sat_value(input logic [SIZE-1:0] wrapped);
      return {~wrapped[SIZE-1], {(SIZE-1){wrapped[SIZE-1]}}};
   endfunction
`endif

   // Stage inputs. Index k is what stage k sees; index 0 comes from the ports.
   logic [SIZE-1:0] w_a_in  [STAGES];
   logic [SIZE-1:0] w_b_in  [STAGES];
   logic [SIZE-1:0] w_s_in  [STAGES];
   logic [SIZE-1:0] w_s_out [STAGES];
   logic            w_c_in  [STAGES];
   logic            w_v_in  [STAGES];
   slice_t          w_slice [STAGES];

   // Inter-stage registers. Only the first LAST entries are used, because the
   // final stage writes the output registers instead.
   logic [SIZE-1:0] r_a   [STAGES];
   logic [SIZE-1:0] r_b   [STAGES];
   logic [SIZE-1:0] r_s   [STAGES];
   logic            r_c   [STAGES];
   logic            r_vld [STAGES];

   logic [SIZE-1:0] r_S;
   logic            r_cout;
   logic            r_ovf;
   logic            w_stall;
   logic            w_ovf;
   logic [SIZE-1:0] w_result;

   // A full output register that is not being taken freezes the whole pipe.
   // in_ready depends only on registered state and on out_ready.
   assign w_stall  = r_vld[LAST] & ~out_ready;
   assign in_ready = ~w_stall;

   // Operand preparation, then every stage's slice evaluation.
   // Operands travel full width, and each stage inserts its own result slice.
   always_comb begin
      w_a_in[0] = A;
      w_b_in[0] = sub ? ~B : B;
      w_s_in[0] = '0;
      w_c_in[0] = sub ? ~Cin : Cin;
      w_v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k] = r_a[k-1];
         w_b_in[k] = r_b[k-1];
         w_s_in[k] = r_s[k-1];
         w_c_in[k] = r_c[k-1];
         w_v_in[k] = r_vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_slice[k] = cla_slice(w_a_in[k][k*BLOCK +: BLOCK],
                                w_b_in[k][k*BLOCK +: BLOCK],
                                w_c_in[k]);
         w_s_out[k] = w_s_in[k];
         w_s_out[k][k*BLOCK +: BLOCK] = w_slice[k].sum;
      end
   end

   assign w_ovf = w_slice[LAST].cmsb ^ w_slice[LAST].cout;

`ifdef PIPELINED_CLA_SAT_EN
   assign w_result = w_ovf ? sat_value(w_s_out[LAST]) : w_s_out[LAST];
`else
   assign w_result = w_s_out[LAST];
`endif

   // ---- stage boundary: valid bits and final-stage output registers ----
   // Outputs only load when a real op arrives, so they hold through bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) r_vld[k] <= 1'b0;
         r_S    <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (!w_stall) begin
         for (int k = 0; k < STAGES; k++) r_vld[k] <= w_v_in[k];
         if (w_v_in[LAST]) begin
            r_S    <= w_result;
            r_cout <= w_slice[LAST].cout;
            r_ovf  <= w_ovf;
         end
      end
   end

   // ---- stage boundary: operand skew, partial results and slice carries ----
   // This is pure datapath, so it is not reset. The valid bits decide what is live.
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         for (int k = 0; k < LAST; k++) begin
            if (w_v_in[k]) begin
               r_a[k] <= w_a_in[k];
               r_b[k] <= w_b_in[k];
               r_s[k] <= w_s_out[k];
               r_c[k] <= w_slice[k].cout;
            end
         end
      end
   end

   assign out_valid = r_vld[LAST];
   assign S         = r_S;
   assign Cout      = r_cout;
   assign Ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder with SIZE=8 and BLOCK=4.
// The driver pushes the expected result of each accepted op.
// The monitor pops an entry for each result handshake and compares it.
module tb_pipelined_cla_adder;
   localparam int SIZE   = 8;
   localparam int BLOCK  = 4;
   localparam int STAGES = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SIZE-1:0] A = '0;
   logic [SIZE-1:0] B = '0;
   logic            Cin = 1'b0;
   logic            sub = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [SIZE-1:0] S;
   logic            Cout;
   logic            Ovf;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.SIZE(SIZE), .BLOCK(BLOCK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .Cout(Cout), .Ovf(Ovf));

   typedef struct {
      logic [SIZE-1:0] s;
      logic            cout;
      logic            ovf;
      int              acc_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   n_issued = 0;
   int   n_recv = 0;
   bit   lat_strict = 1'b0;
   bit   rand_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model using plain integer arithmetic.
   function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                  input logic ci, input logic sb);
      int   ua, ub, sa, sbv, c, full, sr;
      exp_t e;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      c   = ci ? 1 : 0;
      if (!sb) begin
         full   = ua + ub + c;
         sr     = sa + sbv + c;
         e.cout = (full > 255);
      end else begin
         full   = ua - ub - c;
         sr     = sa - sbv - c;
         e.cout = (full >= 0);
      end
      e.s   = full[SIZE-1:0];
      e.ovf = (sr > 127) || (sr < -128);
`ifdef PIPELINED_CLA_SAT_EN
      if (sr > 127) e.s = 8'h7F;
      else if (sr < -128) e.s = 8'h80;
`endif
      e.acc_cyc = 0;
      return e;
   endfunction

   // This task is entered just after a rising edge. It returns just after the
   // rising edge that captured the op, or after a bounded wait expires.
   task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic ci, input logic sb);
      exp_t e;
      int   waited = 0;
      in_valid = 1'b1;
      A = a; B = b; Cin = ci; sub = sb;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e = model(a, b, ci, sb);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
            n_issued++;
            break;
         end
         waited++;
         if (waited > 50) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic issue_rand();
      issue(8'($urandom_range(255)), 8'($urandom_range(255)),
            1'($urandom_range(1)), 1'($urandom_range(1)));
   endtask

   task automatic drain();
      int w = 0;
      while (sb_q.size() != 0 && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: check that outputs hold during a stall and score each handshake.
   logic            prev_stall = 1'b0;
   logic [SIZE-1:0] prev_s = '0;
   logic            prev_c = 1'b0;
   logic            prev_o = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_S", 32'(S), 32'(prev_s));
            chk("stall_hold_Cout", 32'(Cout), 32'(prev_c));
            chk("stall_hold_Ovf", 32'(Ovf), 32'(prev_o));
         end
         if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            chk("result_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               chk("S", 32'(S), 32'(sb_q[0].s));
               chk("Cout", 32'(Cout), 32'(sb_q[0].cout));
               chk("Ovf", 32'(Ovf), 32'(sb_q[0].ovf));
               if (lat_strict) chk("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(STAGES));
               else chk("latency_min", 32'((cyc - sb_q[0].acc_cyc) >= STAGES), 32'd1);
               void'(sb_q.pop_front());
               n_recv <= n_recv + 1;
            end
         end
         prev_stall <= out_valid & ~out_ready;
         prev_s     <= S;
         prev_c     <= Cout;
         prev_o     <= Ovf;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = 1'($urandom_range(1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_S", 32'(S), 32'd0);
      chk("rst_Cout", 32'(Cout), 32'd0);
      chk("rst_Ovf", 32'(Ovf), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      out_ready  = 1'b1;
      lat_strict = 1'b1;

      // Directed add, wrap, overflow and subtract cases
      issue(8'h55, 8'hAA, 1'b0, 1'b0);
      issue(8'h0F, 8'h01, 1'b0, 1'b0);
      issue(8'hFF, 8'h01, 1'b0, 1'b0);
      issue(8'h7F, 8'h01, 1'b0, 1'b0);
      issue(8'h80, 8'hFF, 1'b0, 1'b0);
      issue(8'h05, 8'h07, 1'b0, 1'b1);
      issue(8'h10, 8'h01, 1'b1, 1'b1);
      issue(8'h80, 8'h01, 1'b0, 1'b1);
      drain();

      // Back-to-back random streaming
      for (int i = 0; i < 16; i++) issue_rand();
      drain();

      // Backpressure: stall the first result for three cycles
      lat_strict = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) issue_rand();
         end
         begin
            int w = 0;
            while (!out_valid && w < 20) begin
               @(posedge clk); #1;
               w++;
            end
            chk("bp_first_result", 32'(out_valid), 32'd1);
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Random traffic with random readiness and input gaps
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         issue_rand();
         if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();

      // Reset in the middle of operation: two ops are in flight
      lat_strict = 1'b1;
      issue(8'h12, 8'h34, 1'b0, 1'b0);
      issue(8'h9A, 8'h0B, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_S", 32'(S), 32'd0);
      chk("midrst_Cout", 32'(Cout), 32'd0);
      chk("midrst_Ovf", 32'(Ovf), 32'd0);
      n_issued -= sb_q.size();
      sb_q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_result", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      issue(8'h21, 8'h43, 1'b1, 1'b0);
      drain();

      chk("all_delivered", 32'(n_recv), 32'(n_issued));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
